prog_fetch_unit: RTL

- Parametrised successor to the fixed 6-bit program counter and hard-wired instruction ROM pair.
- Combines a writable instruction memory, loaded through the top-level `write`/`program_in` inputs, with a program counter.
- The program counter supports increment, absolute jump, end-of-program halt and restart.
- Sits between the top level and the controller: supplies `code` to controller/datapath and takes `inc_pc` and `jump` from the controller.

---
 rtl/prog_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/prog_fetch_unit.sv
// Program fetch unit: a writable instruction memory combined with a program
// counter. Words are loaded sequentially while idle; execution then steps or
// jumps through the loaded words and halts at the end of the program.
module prog_fetch_unit #(
  parameter int INSTR_W = 23,
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write,
  input  logic [INSTR_W-1:0] program_in,
  input  logic               start,
  input  logic               inc_pc,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] code,
  output logic               running,
  output logic               done,
  output logic [ADDR_W:0]    loaded_count,
  output logic               load_overflow,
  output logic               jump_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]         state;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [ADDR_W:0]    jump_ext;
  logic [ADDR_W:0]    next_ext;

  // Comparisons against loaded_count are done one bit wider so that a full
  // memory (loaded_count == DEPTH) compares correctly.
  assign jump_ext = {1'b0, jump_addr};
  assign next_ext = {1'b0, address} + (ADDR_W+1)'(1);

  // Decide whether this cycle writes a program word and where it goes; a
  // write from HALT restarts the load at word 0.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = loaded_count[ADDR_W-1:0];
    if (write) begin
      if (state == IDLE) begin
        mem_we = (loaded_count < DEPTH_C);
      end else if (state == HALT) begin
        mem_we    = 1'b1;
        mem_waddr = '0;
      end
    end
  end

  // Instruction storage; deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= program_in;
    end
  end

  // Control state, program counter, load counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      address       <= '0;
      loaded_count  <= '0;
      load_overflow <= 1'b0;
      jump_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (write) begin
            if (loaded_count < DEPTH_C) begin
              loaded_count <= loaded_count + (ADDR_W+1)'(1);
            end else begin
              load_overflow <= 1'b1;
            end
          end else if (start && (loaded_count != '0)) begin
            state   <= RUN;
            address <= '0;
          end
        end
        RUN: begin
          if (jump) begin
            if (jump_ext < loaded_count) begin
              address <= jump_addr;
            end else begin
              jump_err <= 1'b1;
              state    <= HALT;
            end
          end else if (inc_pc) begin
            if (next_ext == loaded_count) begin
              state <= HALT;
            end else begin
              address <= address + ADDR_W'(1);
            end
          end
        end
        HALT: begin
          if (write) begin
            state        <= IDLE;
            loaded_count <= (ADDR_W+1)'(1);
          end else if (start) begin
            state         <= RUN;
            address       <= '0;
            jump_err      <= 1'b0;
            load_overflow <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == HALT);
  assign code    = running ? mem[address] : '0;

endmodule
